// File: rtl/rc4_pkg.sv
`default_nettype none
// =============================================================================
//  Module      : rc4_pkg
//  Description : Shared constants and key-schedule state encoding for RC4.
//  Revision    : 1.0
// =============================================================================
package rc4_pkg;

    localparam int S_DEPTH        = 256;
    localparam int KEY_LENGTH     = 3;
    localparam int MESSAGE_LENGTH = 32;

    // Idle cycles between registering an S address and a usable read/next access
    localparam int S_READ_WAIT    = 2;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT      = 4'd1,
        ST_SET_I     = 4'd2,
        ST_WAIT_I    = 4'd3,
        ST_READ_SI   = 4'd4,
        ST_COMPUTE_J = 4'd5,
        ST_SET_J     = 4'd6,
        ST_WAIT_J    = 4'd7,
        ST_READ_SJ   = 4'd8,
        ST_WR_I      = 4'd9,
        ST_WAIT_WI   = 4'd10,
        ST_WR_J      = 4'd11,
        ST_WAIT_WJ   = 4'd12,
        ST_NEXT      = 4'd13,
        ST_DONE      = 4'd14
    } ks_state_t;

endpackage
`default_nettype wire

// File: rtl/rc4_key_schedule_if.sv
`default_nettype none
// =============================================================================
//  Module      : rc4_key_schedule_if
//  Description : Control handshake and S-memory port of the RC4 key schedule.
//  Revision    : 1.0
// =============================================================================
interface rc4_key_schedule_if #(
    parameter int KEY_LENGTH = rc4_pkg::KEY_LENGTH,
    parameter int S_DEPTH    = rc4_pkg::S_DEPTH
);

    logic                         start;
    logic                         done_ack;
    logic [8*KEY_LENGTH-1:0]      secret_key;
    logic [$clog2(S_DEPTH)-1:0]   s_mem_addr;
    logic [7:0]                   s_mem_data_read;
    logic [7:0]                   s_mem_data_write;
    logic                         s_mem_wren;
    logic                         done;

    modport slave (
        input  start,
        input  done_ack,
        input  secret_key,
        input  s_mem_data_read,
        output s_mem_addr,
        output s_mem_data_write,
        output s_mem_wren,
        output done
    );

    modport master (
        output start,
        output done_ack,
        output secret_key,
        output s_mem_data_read,
        input  s_mem_addr,
        input  s_mem_data_write,
        input  s_mem_wren,
        input  done
    );

endinterface
`default_nettype wire

// File: rtl/rc4_key_schedule.sv
`default_nettype none
// =============================================================================
//  Module      : rc4_key_schedule
//  Description : Fills S with the identity permutation, then runs the RC4 KSA.
//  Revision    : 1.0
// =============================================================================
module rc4_key_schedule #(
    parameter int KEY_LENGTH = rc4_pkg::KEY_LENGTH,
    parameter int S_DEPTH    = rc4_pkg::S_DEPTH
) (
    input  wire logic             clk,
    input  wire logic             reset,
    rc4_key_schedule_if.slave     bus
);

    import rc4_pkg::*;

    localparam int c_AW      = $clog2(S_DEPTH);
    localparam int c_KW      = 8 * KEY_LENGTH;
    localparam int c_KIDX_W  = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

    localparam logic [c_AW-1:0]     c_LAST_IDX  = c_AW'(S_DEPTH - 1);
    localparam logic [c_KIDX_W-1:0] c_KIDX_LAST = c_KIDX_W'(KEY_LENGTH - 1);
    localparam logic [1:0]          c_WAIT_INIT = 2'(S_READ_WAIT - 1);

    ks_state_t            r_state,   w_state_nxt;
    logic [c_AW-1:0]      r_i,       w_i_nxt;
    logic [c_AW-1:0]      r_j,       w_j_nxt;
    logic [c_KIDX_W-1:0]  r_key_idx, w_key_idx_nxt;
    logic [7:0]           r_s_i,     w_s_i_nxt;
    logic [7:0]           r_s_j,     w_s_j_nxt;
    logic [c_KW-1:0]      r_key,     w_key_nxt;
    logic [1:0]           r_wait,    w_wait_nxt;
    logic [c_AW-1:0]      r_addr,    w_addr_nxt;
    logic [7:0]           r_wdata,   w_wdata_nxt;
    logic                 r_wren,    w_wren_nxt;
    logic                 r_done,    w_done_nxt;

    logic [7:0]           w_key_bytes [KEY_LENGTH];
    logic [7:0]           w_key_byte;
    logic [c_AW-1:0]      w_j_sum;

    // Byte 0 is the most significant byte of the key
    for (genvar g = 0; g < KEY_LENGTH; g++) begin : g_key_bytes
        assign w_key_bytes[g] = r_key[(KEY_LENGTH-1-g)*8 +: 8];
    end

    assign w_key_byte = w_key_bytes[r_key_idx];
    assign w_j_sum    = r_j + c_AW'(r_s_i) + c_AW'(w_key_byte);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_key_idx <= '0;
            r_s_i     <= '0;
            r_s_j     <= '0;
            r_key     <= '0;
            r_wait    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wren    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_i       <= w_i_nxt;
            r_j       <= w_j_nxt;
            r_key_idx <= w_key_idx_nxt;
            r_s_i     <= w_s_i_nxt;
            r_s_j     <= w_s_j_nxt;
            r_key     <= w_key_nxt;
            r_wait    <= w_wait_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wren    <= w_wren_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_i_nxt       = r_i;
        w_j_nxt       = r_j;
        w_key_idx_nxt = r_key_idx;
        w_s_i_nxt     = r_s_i;
        w_s_j_nxt     = r_s_j;
        w_key_nxt     = r_key;
        w_wait_nxt    = r_wait;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_wren_nxt    = 1'b0;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_key_nxt   = bus.secret_key;
                    w_i_nxt     = '0;
                    w_state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                w_addr_nxt  = r_i;
                w_wdata_nxt = 8'(r_i);
                w_wren_nxt  = 1'b1;
                w_i_nxt     = r_i + 1'b1;
                if (r_i == c_LAST_IDX) begin
                    w_i_nxt       = '0;
                    w_j_nxt       = '0;
                    w_key_idx_nxt = '0;
                    w_state_nxt   = ST_SET_I;
                end
            end
            ST_SET_I: begin
                w_addr_nxt  = r_i;
                w_wait_nxt  = c_WAIT_INIT;
                w_state_nxt = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                w_wait_nxt = r_wait - 1'b1;
                if (r_wait == '0) begin
                    w_state_nxt = ST_READ_SI;
                end
            end
            ST_READ_SI: begin
                w_s_i_nxt   = bus.s_mem_data_read;
                w_state_nxt = ST_COMPUTE_J;
            end
            ST_COMPUTE_J: begin
                w_j_nxt     = w_j_sum;
                w_state_nxt = ST_SET_J;
            end
            ST_SET_J: begin
                w_addr_nxt  = r_j;
                w_wait_nxt  = c_WAIT_INIT;
                w_state_nxt = ST_WAIT_J;
            end
            ST_WAIT_J: begin
                w_wait_nxt = r_wait - 1'b1;
                if (r_wait == '0) begin
                    w_state_nxt = ST_READ_SJ;
                end
            end
            ST_READ_SJ: begin
                w_s_j_nxt   = bus.s_mem_data_read;
                w_state_nxt = ST_WR_I;
            end
            // When i == j both writes land on one address; the later S[j] write wins
            ST_WR_I: begin
                w_addr_nxt  = r_i;
                w_wdata_nxt = r_s_j;
                w_wren_nxt  = 1'b1;
                w_wait_nxt  = c_WAIT_INIT;
                w_state_nxt = ST_WAIT_WI;
            end
            ST_WAIT_WI: begin
                w_wait_nxt = r_wait - 1'b1;
                if (r_wait == '0) begin
                    w_state_nxt = ST_WR_J;
                end
            end
            ST_WR_J: begin
                w_addr_nxt  = r_j;
                w_wdata_nxt = r_s_i;
                w_wren_nxt  = 1'b1;
                w_wait_nxt  = c_WAIT_INIT;
                w_state_nxt = ST_WAIT_WJ;
            end
            ST_WAIT_WJ: begin
                w_wait_nxt = r_wait - 1'b1;
                if (r_wait == '0) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                w_key_idx_nxt = (r_key_idx == c_KIDX_LAST) ? '0 : r_key_idx + 1'b1;
                if (r_i == c_LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_i_nxt     = r_i + 1'b1;
                    w_state_nxt = ST_SET_I;
                end
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
                if (bus.done_ack) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.s_mem_addr       = r_addr;
    assign bus.s_mem_data_write = r_wdata;
    assign bus.s_mem_wren       = r_wren;
    assign bus.done             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rc4_key_schedule.sv
`default_nettype none
// =============================================================================
//  Module      : tb_rc4_key_schedule
//  Description : Scoreboard bench for rc4_key_schedule with a behavioural S RAM.
//  Revision    : 1.0
// =============================================================================
module tb_rc4_key_schedule;

    import rc4_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rc4_key_schedule_if bus ();

    rc4_key_schedule dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous single-port S RAM, registered read data
    logic [7:0] s_mem [256];
    logic [7:0] rd_q;
    always @(posedge clk) begin
        if (bus.s_mem_wren) s_mem[bus.s_mem_addr] <= bus.s_mem_data_write;
        rd_q <= s_mem[bus.s_mem_addr];
    end
    assign bus.s_mem_data_read = rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q [$];
    logic [7:0]  exp_s [256];
    logic [15:0] log_w [$];
    int          log_c [$];
    int          pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write pulse is popped off the scoreboard
    always @(negedge clk) begin
        if (bus.s_mem_wren === 1'b1) begin
            pulses++;
            log_w.push_back({bus.s_mem_addr, bus.s_mem_data_write});
            log_c.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("wren_unexpected", 32'(1), 32'(0));
            end else begin
                chk("wren_addr_data", 32'({bus.s_mem_addr, bus.s_mem_data_write}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Reference RC4 KSA producing the expected write stream and final S
    task automatic push_run(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] j, t, kb;
        exp_q.delete();
        log_w.delete();
        log_c.delete();
        pulses = 0;
        for (int k = 0; k < 256; k++) begin
            s[k] = 8'(k);
            exp_q.push_back({8'(k), 8'(k)});
        end
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       kb = key[23:16];
                1:       kb = key[15:8];
                default: kb = key[7:0];
            endcase
            j = j + s[i] + kb;
            exp_q.push_back({8'(i), s[j]});
            exp_q.push_back({j, s[i]});
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        for (int k = 0; k < 256; k++) exp_s[k] = s[k];
    endtask

    task automatic launch(input logic [23:0] key);
        push_run(key);
        @(posedge clk); #1;
        bus.secret_key = key;
        bus.start      = 1'b1;
    endtask

    // Counts edges with the start-sampling edge as edge 1.
    // mode 1: done_ack at 500, start toggle + key change at 1000; mode 2: reset at 2000
    task automatic wait_done(input int mode, output int lat);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 6000) begin
            @(posedge clk); #1;
            lat++;
            if (mode == 1 && lat == 500)  bus.done_ack = 1'b1;
            if (mode == 1 && lat == 501)  bus.done_ack = 1'b0;
            if (mode == 1 && lat == 1000) begin bus.start = 1'b1; bus.secret_key = 24'hFFFFFF; end
            if (mode == 1 && lat == 1001) bus.start = 1'b0;
            if (mode == 2 && lat == 2000) return;
        end
    endtask

    task automatic end_of_run();
        int bad;
        chk("wren_count", 32'(pulses), 32'd768);
        chk("exp_left", 32'(exp_q.size()), 32'd0);
        bad = 0;
        for (int k = 0; k < 256; k++) if (s_mem[k] !== exp_s[k]) bad++;
        chk("final_s_bad_entries", 32'(bad), 32'd0);
    endtask

    task automatic ack_done();
        @(posedge clk); #1;
        bus.done_ack = 1'b1;
        @(posedge clk); #1;
        bus.done_ack = 1'b0;
        chk("done_after_ack", 32'(bus.done), 32'd0);
        chk("state_after_ack", 32'(dut.r_state), 32'(ST_IDLE));
    endtask

    logic [15:0] hand0   [6];
    logic [15:0] hand249 [8];
    int lat;

    initial begin
        // key 0: i=0 j=0, i=1 j=1 (collisions), i=2 j=3
        hand0   = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
        // key 0x000249: j = 0, 3, 78, 79
        hand249 = '{16'h0000, 16'h0000, 16'h0103, 16'h0301,
                    16'h024E, 16'h4E02, 16'h034F, 16'h4F01};

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.done_ack   = 1'b0;
        bus.secret_key = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_wren", 32'(bus.s_mem_wren), 32'd0);
        chk("reset_addr", 32'(bus.s_mem_addr), 32'd0);
        chk("reset_wdata", 32'(bus.s_mem_data_write), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Key 0: init stream, collisions, latency
        launch(24'h000000);
        wait_done(0, lat);
        chk("latency_key0", 32'(lat), 32'd4354);
        end_of_run();
        chk("init_consecutive", 32'(log_c[255] - log_c[0]), 32'd255);
        for (int k = 0; k < 6; k++) chk("hand_key0", 32'(log_w[256+k]), 32'(hand0[k]));
        ack_done();

        // Key 0x000249, then handshake hold with start held high in DONE
        launch(24'h000249);
        wait_done(0, lat);
        chk("latency_key249", 32'(lat), 32'd4354);
        end_of_run();
        for (int k = 0; k < 8; k++) chk("hand_key249", 32'(log_w[256+k]), 32'(hand249[k]));
        push_run(24'h000249);
        bus.start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("done_held", 32'(bus.done), 32'd1);
        end
        ack_done();
        wait_done(0, lat);
        chk("latency_restart", 32'(lat), 32'd4354);
        end_of_run();
        ack_done();

        // Busy: stray done_ack and start/key change mid-run are ignored
        launch(24'h000249);
        wait_done(1, lat);
        chk("latency_busy", 32'(lat), 32'd4354);
        end_of_run();
        ack_done();

        // Reset mid-operation, asserted between edges
        launch(24'h000249);
        wait_done(2, lat);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_done", 32'(bus.done), 32'd0);
        chk("midreset_wren", 32'(bus.s_mem_wren), 32'd0);
        chk("midreset_addr", 32'(bus.s_mem_addr), 32'd0);
        chk("midreset_wdata", 32'(bus.s_mem_data_write), 32'd0);
        exp_q.delete();
        pulses = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("no_wren_after_reset", 32'(pulses), 32'd0);
        launch(24'h000249);
        wait_done(0, lat);
        chk("latency_after_reset", 32'(lat), 32'd4354);
        end_of_run();
        ack_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
